imm_extend_unit: RTL and testbench

//   Parametrised immediate-extension unit with a valid/ready input port and a DEPTH-entry output FIFO.

---
 rtl/imm_extend_unit_if.sv | 26 ++
 rtl/imm_extend_unit.sv | 76 +++++++
 tb/tb_imm_extend_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imm_extend_unit_if.sv
// Handshake bundle between the decode stage, the immediate-extension unit and the operand mux.
// The master side is the source/consumer pair; the slave side is the extension unit.
interface imm_extend_unit_if #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] extended;
    logic             out_neg;
    logic [4:0]       count;

    modport master (
        output in_valid, imm, mode, out_ready,
        input  in_ready, out_valid, extended, out_neg, count
    );

    modport slave (
        input  in_valid, imm, mode, out_ready,
        output in_ready, out_valid, extended, out_neg, count
    );
endinterface

// File: rtl/imm_extend_unit.sv
// Widens a decode-stage immediate (sign / zero / upper / sign<<1) and queues the result
// in a DEPTH-entry FIFO so execute-stage stalls never drop an immediate.
module imm_extend_unit #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 16,
    parameter int DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    imm_extend_unit_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    initial begin
        if (IN_W < 2 || IN_W > OUT_W - 2 || DEPTH < 1 || DEPTH > 16)
            $error("imm_extend_unit: illegal parameters IN_W=%0d OUT_W=%0d DEPTH=%0d",
                   IN_W, OUT_W, DEPTH);
    end

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [4:0]       cnt, cnt_nxt;
    logic [OUT_W-1:0] head_q, sext, result;
    logic             push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        sext = {{(OUT_W - IN_W){bus.imm[IN_W-1]}}, bus.imm};
        result = sext;
        unique case (bus.mode)
            2'b00: result = sext;
            2'b01: result = {{(OUT_W - IN_W){1'b0}}, bus.imm};
            2'b10: result = {bus.imm, {(OUT_W - IN_W){1'b0}}};
            2'b11: result = {sext[OUT_W-2:0], 1'b0};
            default: result = sext;
        endcase
    end

    // in_ready depends only on registered count and rst, never on out_ready.
    assign bus.in_ready  = (cnt < 5'(DEPTH)) & ~rst;
    assign bus.out_valid = (cnt != 5'd0);
    assign bus.extended  = head_q;
    assign bus.out_neg   = head_q[OUT_W-1];
    assign bus.count     = cnt;

    always_comb begin
        push       = bus.in_valid & bus.in_ready;
        pop        = bus.out_valid & bus.out_ready;
        cnt_nxt    = cnt + 5'(push) - 5'(pop);
        rd_ptr_nxt = pop ? inc(rd_ptr) : rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= result;
    end

    // head_q mirrors the next head; when the queue drains to empty it keeps the last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            if (cnt_nxt != 5'd0)
                head_q <= ((cnt - 5'(pop)) == 5'd0) ? result : mem[rd_ptr_nxt];
        end
    end
endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed-vector bench for imm_extend_unit (IN_W=5, OUT_W=16, DEPTH=2).
module tb_imm_extend_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    imm_extend_unit_if #(.IN_W(5), .OUT_W(16)) bus ();

    imm_extend_unit #(.IN_W(5), .OUT_W(16), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready_hi got %0b exp 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", bus.count); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
        tests++; if (bus.extended !== 16'h0000) begin fails++; $display("FAIL rst_extended got %h exp 0000", bus.extended); end
        tests++; if (bus.out_neg !== 1'b0) begin fails++; $display("FAIL rst_out_neg got %0b exp 0", bus.out_neg); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b exp 1", bus.in_ready); end
    endtask

    task automatic test_modes;
        logic [15:0] exp_e [4];
        logic        exp_n [4];
        exp_e = '{16'hFFF2, 16'h0012, 16'h9000, 16'hFFE4};
        exp_n = '{1'b1, 1'b0, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            bus.in_valid = 1'b1;
            bus.imm      = 5'b10010;
            bus.mode     = 2'(m);
            step();
            bus.in_valid = 1'b0;
            tests++; if (bus.extended !== exp_e[m]) begin fails++; $display("FAIL mode%0d_extended got %h exp %h", m, bus.extended, exp_e[m]); end
            tests++; if (bus.out_neg !== exp_n[m]) begin fails++; $display("FAIL mode%0d_out_neg got %0b exp %0b", m, bus.out_neg, exp_n[m]); end
            tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL mode%0d_count got %0d exp 1", m, bus.count); end
        end
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL modes_drain_valid got %0b exp 0", bus.out_valid); end
        tests++; if (bus.extended !== 16'hFFE4) begin fails++; $display("FAIL modes_hold got %h exp FFE4", bus.extended); end
        step();
        tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL empty_pop_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_values;
        logic [4:0]  vi [3];
        logic [15:0] ve [3];
        vi = '{5'b00010, 5'b01111, 5'b10000};
        ve = '{16'h0002, 16'h000F, 16'hFFF0};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.imm      = vi[k];
            bus.mode     = 2'b00;
            step();
            bus.in_valid = 1'b0;
            tests++; if (bus.extended !== ve[k]) begin fails++; $display("FAIL value%0d_extended got %h exp %h", k, bus.extended, ve[k]); end
            tests++; if (bus.out_neg !== ve[k][15]) begin fails++; $display("FAIL value%0d_out_neg got %0b exp %0b", k, bus.out_neg, ve[k][15]); end
        end
        step();
    endtask

    task automatic test_back_pressure;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.imm = 5'd1; bus.mode = 2'b00;
        step();
        bus.imm = 5'd2; bus.mode = 2'b01;
        step();
        bus.imm = 5'd3; bus.mode = 2'b10;
        tests++; if (bus.count !== 5'd2) begin fails++; $display("FAIL bp_count got %0d exp 2", bus.count); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %0b exp 0", bus.in_ready); end
        step();
        step();
        tests++; if (bus.count !== 5'd2) begin fails++; $display("FAIL bp_full_count got %0d exp 2", bus.count); end
        tests++; if (bus.extended !== 16'h0001) begin fails++; $display("FAIL bp_head0 got %h exp 0001", bus.extended); end
        bus.out_ready = 1'b1;
        step();
        tests++; if (bus.extended !== 16'h0002) begin fails++; $display("FAIL bp_head1 got %h exp 0002", bus.extended); end
        tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL bp_count1 got %0d exp 1", bus.count); end
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.extended !== 16'h1800) begin fails++; $display("FAIL bp_head2 got %h exp 1800", bus.extended); end
        tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL bp_count2 got %0d exp 1", bus.count); end
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_throughput;
        bus.out_ready = 1'b1;
        bus.mode      = 2'b00;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.imm      = 5'(i);
            step();
            tests++; if (bus.extended !== 16'(i)) begin fails++; $display("FAIL tp%0d_extended got %h exp %h", i, bus.extended, 16'(i)); end
            tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL tp%0d_count got %0d exp 1", i, bus.count); end
        end
        bus.in_valid = 1'b0;
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL tp_drain got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_mid_reset;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.imm = 5'b11000; bus.mode = 2'b00;
        step();
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.count !== 5'd2) begin fails++; $display("FAIL mr_pre_count got %0d exp 2", bus.count); end
        rst = 1'b1;
        step();
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mr_in_ready_hi got %0b exp 0", bus.in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL mr_count got %0d exp 0", bus.count); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mr_out_valid got %0b exp 0", bus.out_valid); end
        tests++; if (bus.extended !== 16'h0000) begin fails++; $display("FAIL mr_extended got %h exp 0000", bus.extended); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mr_in_ready got %0b exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        step();
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mr_ghost got %0b exp 0", bus.out_valid); end
    endtask

    task automatic test_push_pop_count1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.imm = 5'd4; bus.mode = 2'b01;
        step();
        tests++; if (bus.extended !== 16'h0004) begin fails++; $display("FAIL pp_head0 got %h exp 0004", bus.extended); end
        bus.out_ready = 1'b1;
        bus.imm = 5'b11111; bus.mode = 2'b11;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.count !== 5'd1) begin fails++; $display("FAIL pp_count got %0d exp 1", bus.count); end
        tests++; if (bus.extended !== 16'hFFFE) begin fails++; $display("FAIL pp_head1 got %h exp FFFE", bus.extended); end
        tests++; if (bus.out_neg !== 1'b1) begin fails++; $display("FAIL pp_out_neg got %0b exp 1", bus.out_neg); end
        step();
        tests++; if (bus.count !== 5'd0) begin fails++; $display("FAIL pp_drain got %0d exp 0", bus.count); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.imm       = '0;
        bus.mode      = 2'b00;
        test_reset();
        test_modes();
        test_values();
        test_back_pressure();
        test_throughput();
        test_mid_reset();
        test_push_pop_count1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
